sa_ctrl: RTL and testbench
==========================

# sa_ctrl

Sequencing controller for the N×N weight-stationary systolic array built from the team's PE (8-bit Q1.6 weight, 16-bit Q5.10 activation, 24-bit Q7.16 accumulate). It accepts a job (optional weight reload plus a count of activation vectors) and loads weights row by row through the PEs' weight-load ports. It then streams activation vectors into the array's left edge with per-row skew and flags when each bottom-edge column result is valid. It sits between the job/DMA front end and the array wrapper; the wrapper ties the top-row Acc_in to zero.

## Interface
- N, 4, array dimension (rows = columns)
- VEC_CNT_W, 8, width of the vector-count field
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  job request; sampled only in IDLE
- reload_w  in  1  sampled with start; 1 = load weights before streaming
- num_vec  in  VEC_CNT_W  activation vectors in the job; sampled with start
- busy  out  1  high in LOAD_W, STREAM and DRAIN
- done  out  1  one-cycle pulse in the DONE state
- w_valid / w_ready  in / out  1  weight-row handshake
- w_data  in  8*N  one weight row; lane c goes to column c
- w_load_en  out  N  one-hot row enable to the PE W_load_en ports
- w_load_data  out  8*N  registered weight row to the PE W_load_data ports
- a_valid / a_ready  in / out  1  activation-vector handshake
- a_data  in  16*N  one vector; lane r goes to row r
- arr_a  out  16*N  skewed activations to the array row inputs
- col_valid  out  N  bit c high when the bottom output of column c carries a valid result

## Operation
- States and transitions:
  - IDLE: start with reload_w=1 → LOAD_W. start with reload_w=0 and num_vec≠0 → STREAM. start with reload_w=0 and num_vec=0 → DONE.
  - LOAD_W: w_ready=1. Each accepted beat loads the next row, 0..N-1 in order. After row N-1 → STREAM, or → DONE if num_vec=0.
  - STREAM: a_ready=1 until num_vec vectors are accepted, then → DRAIN. a_valid=0 cycles are bubbles; there is no timeout.
  - DRAIN: stays until col_valid[N-1] for the final vector has pulsed, then → DONE.
  - DONE: one cycle, then → IDLE.
- start outside IDLE is ignored. w_ready=0 outside LOAD_W; a_ready=0 outside STREAM.
- Weights are never loaded while vectors are in flight. LOAD_W is entered only from IDLE, where the pipeline is already drained.
- Skew: row r input is delayed by 2r cycles, matching the PE's 2-cycle Acc path.
- Bubble rule: any arr_a lane without a valid vector behind it is driven to 0. PEs accumulate every cycle, so a zero input keeps the bubble product at zero.
- A valid bit travels alongside each vector through the skew/de-skew logic and produces col_valid.
- Reset mid-job: state returns to IDLE, all skew registers clear, the in-progress job is abandoned, and the front end must restart the job.

## Timing
- Reset values: busy, done, w_ready, a_ready, w_load_en, w_load_data, arr_a and col_valid are all 0.
- Weight load: for a handshake at cycle T, w_load_en has the row's bit set with w_load_data during cycle T+1, for exactly one cycle.
- Activations: for a handshake at T, arr_a lane r carries the vector during T+1+2r.
- Results: col_valid[c] pulses at T+2N+1+c (N=4: column 0 at T+9, column 3 at T+12).
- done asserts the cycle after the last col_valid[N-1] pulse; busy is 0 in that cycle.
- Back-to-back vectors are accepted at 1 per cycle.
- Back-to-back jobs: the earliest start that is accepted is the cycle after done.

## Configuration
- SA_CTRL_PERF_EN defined adds two 32-bit outputs:
  - perf_busy_cycles: busy cycles of the last job.
  - perf_stall_cycles: STREAM cycles with a_valid=0.
  - Both clear when a start is accepted and hold after done.
- SA_CTRL_PERF_EN undefined: the ports and counters are absent.

## Structure
- Shared package sa_pkg holds:
  - PE widths W_W=8, A_W=16, ACC_W=24.
  - PE latencies PE_ACC_LAT=2, PE_A_LAT=1.
  - The state enum {IDLE, LOAD_W, STREAM, DRAIN, DONE}.
- One sub-module, sa_skew_line: a parameterized-depth delay line of data plus valid bit, with synchronous clear. It is instantiated per row for input skew and per column for col_valid alignment.

## Test plan
- Reset then idle: all outputs 0; start with num_vec=0, reload_w=0 → done pulses the next cycle and busy never rises.
- Weight load (N=4): 4 rows with w_valid held high → w_load_en sequence 0001, 0010, 0100, 1000 at T+1..T+4, with the matching w_load_data.
- Stream 3 vectors back-to-back with PE models attached → col_valid[0] at T0+9, col_valid[3] at T2+12, sums match the reference matrix product, done at T2+13.
- a_valid bubbles mid-stream → the affected arr_a lanes are 0 during bubbles, results are unaffected, and perf_stall_cycles equals the bubble count with SA_CTRL_PERF_EN defined.
- start pulsed during STREAM → ignored; num_vec is not resampled.
- rst_n low mid-DRAIN for 1 cycle → next cycle is IDLE with arr_a=0 and col_valid=0; a fresh job then completes correctly.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared PE widths, PE latencies and controller state encoding
package sa_pkg;

    localparam int W_W   = 8;
    localparam int A_W   = 16;
    localparam int ACC_W = 24;

    localparam int PE_ACC_LAT = 2;
    localparam int PE_A_LAT   = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } sa_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - fixed-depth delay line carrying a data word and its valid bit
module sa_skew_line #(
    parameter int W = 16,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data [D];
    logic [D-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            for (int i = 0; i < D; i++) r_data[i] <= '0;
            r_valid <= '0;
        end else begin
            r_data[0]  <= i_data;
            r_valid[0] <= i_valid;
            for (int i = 1; i < D; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign o_data  = r_data[D-1];
    assign o_valid = r_valid[D-1];

endmodule

// File: rtl/sa_ctrl.sv
// rtl/sa_ctrl.sv - systolic array job sequencer: weight load, skewed streaming, drain (SA_CTRL_PERF_EN adds perf counters)
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int N         = 4,
    parameter int VEC_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 reload_w,
    input  logic [VEC_CNT_W-1:0] num_vec,
    output logic                 busy,
    output logic                 done,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [W_W*N-1:0]     w_data,
    output logic [N-1:0]         w_load_en,
    output logic [W_W*N-1:0]     w_load_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [A_W*N-1:0]     a_data,
    output logic [A_W*N-1:0]     arr_a,
    output logic [N-1:0]         col_valid
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_busy_cycles,
    output logic [31:0]          perf_stall_cycles
`endif
);

    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(N - 1);
    localparam logic [VEC_CNT_W-1:0] ONE      = VEC_CNT_W'(1);

    sa_state_e              r_state;
    logic                   r_busy, r_done, r_w_ready, r_a_ready;
    logic [N-1:0]           r_w_load_en;
    logic [W_W*N-1:0]       r_w_load_data;
    logic [ROW_W-1:0]       r_row;
    logic [VEC_CNT_W-1:0]   r_num_vec, r_in_cnt, r_out_cnt;

    logic                   w_w_fire, w_a_fire, w_clr, w_col_last;
    logic [N-1:0]           w_row_valid, w_col_data, w_col_vld;
    logic [A_W-1:0]         w_row_data [N];

    assign w_w_fire   = w_valid & r_w_ready;
    assign w_a_fire   = a_valid & r_a_ready;
    assign w_clr      = (r_state == IDLE);
    assign w_col_last = col_valid[N-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_w_ready     <= 1'b0;
            r_a_ready     <= 1'b0;
            r_w_load_en   <= '0;
            r_w_load_data <= '0;
            r_row         <= '0;
            r_num_vec     <= '0;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
        end else begin
            r_w_load_en   <= '0;
            r_w_load_data <= '0;
            r_done        <= 1'b0;
            if (w_col_last) r_out_cnt <= r_out_cnt + ONE;
            case (r_state)
                IDLE: if (start) begin
                    r_num_vec <= num_vec;
                    r_in_cnt  <= '0;
                    r_out_cnt <= '0;
                    r_row     <= '0;
                    if (reload_w) begin
                        r_state   <= LOAD_W;
                        r_busy    <= 1'b1;
                        r_w_ready <= 1'b1;
                    end else if (num_vec != '0) begin
                        r_state   <= STREAM;
                        r_busy    <= 1'b1;
                        r_a_ready <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                LOAD_W: if (w_w_fire) begin
                    r_w_load_en   <= N'(1) << r_row;
                    r_w_load_data <= w_data;
                    r_row         <= r_row + ROW_W'(1);
                    if (r_row == LAST_ROW) begin
                        r_w_ready <= 1'b0;
                        if (r_num_vec == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= STREAM;
                            r_a_ready <= 1'b1;
                        end
                    end
                end
                STREAM: if (w_a_fire) begin
                    r_in_cnt <= r_in_cnt + ONE;
                    if (r_in_cnt == r_num_vec - ONE) begin
                        r_a_ready <= 1'b0;
                        r_state   <= DRAIN;
                    end
                end
                // The final vector has left the array once the last column reports it.
                DRAIN: if (w_col_last && (r_out_cnt == r_num_vec - ONE)) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar r = 0; r < N; r++) begin : g_row
            sa_skew_line #(.W(A_W), .D(PE_ACC_LAT * r + PE_A_LAT)) u_row (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_clr   (w_clr),
                .i_data  (a_data[r*A_W +: A_W]),
                .i_valid (w_a_fire),
                .o_data  (w_row_data[r]),
                .o_valid (w_row_valid[r])
            );
            assign arr_a[r*A_W +: A_W] = w_row_valid[r] ? w_row_data[r] : '0;
        end
        // Column c sees the bottom-row vector after the Acc path plus c steps across the row.
        for (genvar c = 0; c < N; c++) begin : g_col
            sa_skew_line #(.W(1), .D(PE_ACC_LAT + c * PE_A_LAT)) u_col (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_clr   (w_clr),
                .i_data  (w_row_valid[N-1]),
                .i_valid (w_row_valid[N-1]),
                .o_data  (w_col_data[c]),
                .o_valid (w_col_vld[c])
            );
        end
    endgenerate

    assign col_valid   = w_col_data & w_col_vld;
    assign busy        = r_busy;
    assign done        = r_done;
    assign w_ready     = r_w_ready;
    assign a_ready     = r_a_ready;
    assign w_load_en   = r_w_load_en;
    assign w_load_data = r_w_load_data;

`ifdef SA_CTRL_PERF_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (r_state == IDLE && start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy) r_perf_busy <= r_perf_busy + 32'd1;
            if (r_state == STREAM && !a_valid) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb/tb_sa_ctrl.sv - directed self-checking bench for sa_ctrl
module tb_sa_ctrl;

    localparam int N  = 4;
    localparam int VW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, reload_w;
    logic [VW-1:0]     num_vec;
    logic              busy, done;
    logic              w_valid, w_ready;
    logic [8*N-1:0]    w_data;
    logic [N-1:0]      w_load_en;
    logic [8*N-1:0]    w_load_data;
    logic              a_valid, a_ready;
    logic [16*N-1:0]   a_data;
    logic [16*N-1:0]   arr_a;
    logic [N-1:0]      col_valid;
`ifdef SA_CTRL_PERF_EN
    logic [31:0]       perf_busy_cycles, perf_stall_cycles;
`endif

    sa_ctrl #(.N(N), .VEC_CNT_W(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .reload_w    (reload_w),
        .num_vec     (num_vec),
        .busy        (busy),
        .done        (done),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .w_load_en   (w_load_en),
        .w_load_data (w_load_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_data      (a_data),
        .arr_a       (arr_a),
        .col_valid   (col_valid)
`ifdef SA_CTRL_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          acc_t [8];
    logic [63:0] vecs  [8];
    logic [31:0] wts   [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic rl, input logic [VW-1:0] nv);
        start    = 1'b1;
        reload_w = rl;
        num_vec  = nv;
        tick();
        start    = 1'b0;
        reload_w = 1'b0;
    endtask

    // Cycle t=0 is the first STREAM cycle; vector j is offered at acc_t[j].
    task automatic run_stream(input int nv, input int tlen, input bit start_mid);
        logic [63:0] e_arr;
        logic [N-1:0] e_cv;
        int last;
        last = acc_t[nv-1];
        for (int t = 0; t < tlen; t++) begin
            a_valid = 1'b0;
            a_data  = 64'hA5A5_5A5A_F00D_BEEF;
            for (int j = 0; j < nv; j++)
                if (acc_t[j] == t) begin
                    a_valid = 1'b1;
                    a_data  = vecs[j];
                end
            start   = start_mid && (t == 1);
            num_vec = start_mid ? 8'd5 : num_vec;
            e_arr = '0;
            e_cv  = '0;
            for (int j = 0; j < nv; j++) begin
                for (int r = 0; r < N; r++)
                    if (t == acc_t[j] + 1 + 2*r) e_arr[r*16 +: 16] = vecs[j][r*16 +: 16];
                for (int c = 0; c < N; c++)
                    if (t == acc_t[j] + 9 + c) e_cv[c] = 1'b1;
            end
            chk($sformatf("arr_a t=%0d", t), arr_a, e_arr);
            chk($sformatf("col_valid t=%0d", t), {60'd0, col_valid}, {60'd0, e_cv});
            chk($sformatf("done t=%0d", t), {63'd0, done}, {63'd0, (t == last + 13)});
            chk($sformatf("busy t=%0d", t), {63'd0, busy}, {63'd0, (t < last + 13)});
            chk($sformatf("a_ready t=%0d", t), {63'd0, a_ready}, {63'd0, (t <= last)});
            tick();
        end
        start   = 1'b0;
        a_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        reload_w = 1'b0;
        num_vec  = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        a_valid  = 1'b0;
        a_data   = '0;
        wts[0] = 32'h0403_0201;
        wts[1] = 32'h1413_1211;
        wts[2] = 32'h2423_2221;
        wts[3] = 32'h3433_3231;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst busy",        {63'd0, busy},    64'd0);
        chk("rst done",        {63'd0, done},    64'd0);
        chk("rst w_ready",     {63'd0, w_ready}, 64'd0);
        chk("rst a_ready",     {63'd0, a_ready}, 64'd0);
        chk("rst w_load_en",   {60'd0, w_load_en}, 64'd0);
        chk("rst w_load_data", {32'd0, w_load_data}, 64'd0);
        chk("rst arr_a",       arr_a, 64'd0);
        chk("rst col_valid",   {60'd0, col_valid}, 64'd0);

        // Empty job without reload finishes immediately.
        do_start(1'b0, 8'd0);
        chk("zero done",  {63'd0, done}, 64'd1);
        chk("zero busy",  {63'd0, busy}, 64'd0);
        tick();
        chk("zero done2", {63'd0, done}, 64'd0);
        chk("zero busy2", {63'd0, busy}, 64'd0);

        // Weight reload then 3 back-to-back vectors.
        do_start(1'b1, 8'd3);
        chk("ld w_ready", {63'd0, w_ready}, 64'd1);
        chk("ld busy",    {63'd0, busy},    64'd1);
        chk("ld a_ready", {63'd0, a_ready}, 64'd0);
        w_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            w_data = wts[i];
            tick();
            chk($sformatf("w_load_en row%0d", i),   {60'd0, w_load_en},   64'(1 << i));
            chk($sformatf("w_load_data row%0d", i), {32'd0, w_load_data}, {32'd0, wts[i]});
        end
        w_valid = 1'b0;
        chk("ld w_ready end", {63'd0, w_ready}, 64'd0);
        vecs[0] = 64'h0004_0003_0002_0001;
        vecs[1] = 64'h0040_0030_0020_0010;
        vecs[2] = 64'h0400_0300_0200_0100;
        acc_t[0] = 0; acc_t[1] = 1; acc_t[2] = 2;
        run_stream(3, 17, 1'b0);
        chk("post w_load_en", {60'd0, w_load_en}, 64'd0);

        // Two vectors with a 2-cycle bubble and a stray start mid-stream.
        do_start(1'b0, 8'd2);
        vecs[0] = 64'h1111_2222_3333_4444;
        vecs[1] = 64'h5555_6666_7777_8888;
        acc_t[0] = 0; acc_t[1] = 3;
        run_stream(2, 19, 1'b1);
`ifdef SA_CTRL_PERF_EN
        chk("perf stall", {32'd0, perf_stall_cycles}, 64'd2);
        chk("perf busy",  {32'd0, perf_busy_cycles},  64'd16);
`endif

        // Reset in DRAIN abandons the job; a fresh job then runs clean.
        do_start(1'b0, 8'd1);
        vecs[0] = 64'h0009_0008_0007_0006;
        acc_t[0] = 0;
        run_stream(1, 7, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid-rst busy",      {63'd0, busy},       64'd0);
        chk("mid-rst a_ready",   {63'd0, a_ready},    64'd0);
        chk("mid-rst arr_a",     arr_a,               64'd0);
        chk("mid-rst col_valid", {60'd0, col_valid},  64'd0);
        do_start(1'b0, 8'd1);
        vecs[0] = 64'h00AB_00CD_00EF_0012;
        run_stream(1, 15, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
